// File: rtl/ad_buf_burst_framer_if.sv
// Bundle of the prefetch-FIFO read port and the HSST TX lane port.
// master: the framer (pops the FIFO, drives the lane).
// slave : the surrounding FIFO / lane logic.
interface ad_buf_burst_framer_if;
    logic [31:0] fifo_data;
    logic        fifo_vld;
    logic        fifo_en;
    logic [31:0] tx_data;
    logic [3:0]  tx_k;
    logic        tx_rdy;

    modport master (
        input  fifo_data,
        input  fifo_vld,
        input  tx_rdy,
        output fifo_en,
        output tx_data,
        output tx_k
    );

    modport slave (
        output fifo_data,
        output fifo_vld,
        output tx_rdy,
        input  fifo_en,
        input  tx_data,
        input  tx_k
    );
endinterface

// File: rtl/ad_buf_burst_framer.sv
// AD prefetch FIFO read-side framer: pops 32-bit words and frames them into
// HEAD / BURST_LEN x DATA / TAIL bursts for the HSST TX lane. FILL words are
// inserted whenever the FIFO runs dry inside a burst; IDLE words between bursts.
module ad_buf_burst_framer #(
    parameter int unsigned BURST_LEN = 64
) (
    input  logic                          rd_clk,
    input  logic                          rd_rst,
    ad_buf_burst_framer_if.master         bus,
    output logic [7:0]                    seq,
    output logic [15:0]                   burst_cnt,
    output logic                          busy
);

    localparam logic [31:0] IDLE_WORD = 32'h5050_50BC;
    localparam logic [3:0]  K_CTRL    = 4'b0001;
    localparam logic [3:0]  K_DATA    = 4'b0000;
    localparam logic [15:0] LEN16     = 16'(BURST_LEN);
    localparam logic [15:0] LAST_IDX  = 16'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_TAIL
    } state_t;

    state_t      state_q,     state_d;
    logic [15:0] cnt_q,       cnt_d;
    logic [15:0] csum_q,      csum_d;
    logic [7:0]  seq_q,       seq_d;
    logic [15:0] burst_cnt_q, burst_cnt_d;
    logic [31:0] tx_data_q,   tx_data_d;
    logic [3:0]  tx_k_q,      tx_k_d;

    // Next-state and next-output logic; nothing moves unless the lane advances.
    always_comb begin
        // NOTE: every variable gets a hold default first so no path infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        csum_d      = csum_q;
        seq_d       = seq_q;
        burst_cnt_d = burst_cnt_q;
        tx_data_d   = tx_data_q;
        tx_k_d      = tx_k_q;

        if (bus.tx_rdy) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.fifo_vld) begin
                        // Header is generated locally; the FIFO is not popped here.
                        tx_data_d = {LEN16, seq_q, 8'hFB};
                        tx_k_d    = K_CTRL;
                        cnt_d     = '0;
                        csum_d    = '0;
                        state_d   = ST_DATA;
                    end else begin
                        tx_data_d = IDLE_WORD;
                        tx_k_d    = K_CTRL;
                    end
                end

                ST_DATA: begin
                    if (bus.fifo_vld) begin
                        tx_data_d = bus.fifo_data;
                        tx_k_d    = K_DATA;
                        cnt_d     = cnt_q + 16'd1;
                        csum_d    = csum_q + bus.fifo_data[31:16] + bus.fifo_data[15:0];
                        if (cnt_q == LAST_IDX) begin
                            state_d = ST_TAIL;
                        end
                    end else begin
                        // FIFO dry mid-burst: keep the lane aligned with FILL.
                        tx_data_d = IDLE_WORD;
                        tx_k_d    = K_CTRL;
                    end
                end

                ST_TAIL: begin
                    tx_data_d   = {csum_q, 8'h00, 8'hFD};
                    tx_k_d      = K_CTRL;
                    seq_d       = seq_q + 8'd1;
                    burst_cnt_d = burst_cnt_q + 16'd1;
                    state_d     = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset to an idle lane.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            csum_q      <= '0;
            seq_q       <= '0;
            burst_cnt_q <= '0;
            tx_data_q   <= IDLE_WORD;
            tx_k_q      <= K_CTRL;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            csum_q      <= csum_d;
            seq_q       <= seq_d;
            burst_cnt_q <= burst_cnt_d;
            tx_data_q   <= tx_data_d;
            tx_k_q      <= tx_k_d;
        end
    end

    // Pop only while carrying payload and the lane is advancing.
    always_comb begin
        bus.fifo_en = (state_q == ST_DATA) && bus.tx_rdy;
    end

    assign bus.tx_data = tx_data_q;
    assign bus.tx_k    = tx_k_q;
    assign seq         = seq_q;
    assign burst_cnt   = burst_cnt_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
